imx415_cfg_seq: RTL and testbench
=================================

// Module: imx415_cfg_seq
// PURPOSE
//  Sequencer between the IMX415 register LUT (index -> {addr16,data8}, size) and the I2C byte-write master.
//  Waits out sensor power-up, walks LUT entries 0..size-1 issuing one 16-bit-address write each,
//  retries NACKed writes, then releases STANDBY (0x3000=0x00), waits, starts master (0x3002=0x00).
//  Flags done/error to top level, which gates MIPI RX reset release.
// PARAMETERS
//  DEV_ADDR     7'h1A   sensor 7-bit I2C slave address
//  PWRUP_CYC    24'd2_500_000  cycles from start to first write (20 ms @125 MHz)
//  STBY_CYC     24'd3_125_000  cycles between STANDBY release and XMSTA write (25 ms @125 MHz)
//  RETRY_MAX    2       re-issues allowed per write after NACK (3 attempts total)
// PORTS
//  I_clk        in   1   system clock
//  I_rst        in   1   asynchronous reset, active high
//  I_start      in   1   level/pulse; rising edge sampled in IDLE/DONE/ERROR starts a run
//  O_reg_index  out  9   LUT index
//  I_reg_data   in   32  LUT entry, [23:8]=reg addr, [7:0]=data, combinational from O_reg_index
//  I_reg_size   in   8   number of LUT entries
//  O_wr_req     out  1   write request valid to I2C master
//  I_wr_rdy     in   1   master accepts when O_wr_req&&I_wr_rdy
//  O_wr_dev     out  7   slave address (=DEV_ADDR)
//  O_wr_addr    out  16  register address
//  O_wr_data    out  8   register data
//  I_wr_done    in   1   one-cycle completion pulse
//  I_wr_nack    in   1   valid with I_wr_done; 1 = NACK seen
//  O_busy       out  1   high in any state except IDLE/DONE/ERROR
//  O_cfg_done   out  1   sticky, high in DONE
//  O_cfg_err    out  1   sticky, high in ERROR
//  O_err_index  out  9   LUT index of failed write (9'h1FF = standby/XMSTA phase)
// BEHAVIOUR
//  Reset: all outputs 0 except O_err_index=0; state IDLE; timer=0; retry=0. Reset mid-run aborts silently.
//  Clocking: single domain; async reset only; I2C master handshake is on I_clk.
//  States: IDLE -> PWR_WAIT -> FETCH -> ISSUE -> WAIT_DONE -> (FETCH | STBY_ISSUE)
//          STBY_ISSUE -> STBY_WAIT_DONE -> STBY_DLY -> XM_ISSUE -> XM_WAIT_DONE -> DONE; any fail -> ERROR.
//  IDLE/DONE/ERROR: I_start rising edge (registered prev) -> PWR_WAIT, clear done/err, index=0, retry=0.
//  PWR_WAIT: counts PWRUP_CYC cycles; then FETCH if I_reg_size!=0 else STBY_ISSUE.
//  FETCH: one cycle; latches I_reg_data[23:0] into O_wr_addr/O_wr_data (LUT settled from prior cycle).
//  ISSUE: O_wr_req=1, fields stable until I_wr_rdy; handshake cycle -> WAIT_DONE, req drops next cycle.
//  WAIT_DONE on I_wr_done: ack -> retry=0; index==size-1 ? STBY_ISSUE : index+1, FETCH.
//          nack -> retry<RETRY_MAX ? retry+1, ISSUE (same entry) : ERROR, O_err_index=index.
//  I_wr_done outside a WAIT state ignored. I_start edges outside IDLE/DONE/ERROR ignored.
//  STBY_ISSUE writes {0x3000,0x00}; STBY_DLY counts STBY_CYC; XM_ISSUE writes {0x3002,0x00}; same retry rules,
//          failure sets O_err_index=9'h1FF.
//  Index compare uses {1'b0,I_reg_size}-1 at 9 bits; index never exceeds 254, no wrap.
//  Timer: 24-bit down counter loaded on state entry; transition when it reaches 0 (exactly N cycles).
// STRUCTURE
//  Package imx415_cfg_pkg: state encoding localparams, REG_STANDBY=16'h3000, REG_XMSTA=16'h3002,
//          SENSOR_I2C_ADDR=7'h1A, ERR_IDX_POST=9'h1FF.
//  Sub-module cfg_delay_timer (24-bit load/count/expire); FSM and write-field regs in this file.
// TESTING
//  Bench uses PWRUP_CYC=10, STBY_CYC=20, LUT model size 201 and I2C model with programmable rdy/nack.
//  1 Start, always-ack master -> 203 writes; first {0x3000,0x01}, #200 {0x4074,0x01}, then 0x3000=00, 0x3002=00;
//    first O_wr_req exactly 10 cycles after PWR_WAIT entry, O_cfg_done=1, O_cfg_err=0.
//  2 NACK entry 5 twice then ack -> 3 requests with addr 0x3008 data 0x5D, run completes done.
//  3 NACK entry 7 three times -> ERROR, O_cfg_err=1, O_err_index=7, no further requests.
//  4 I_wr_rdy held low 50 cycles in ISSUE -> O_wr_req, addr, data stable throughout; one write only.
//  5 I_reg_size=0 -> only 0x3000 and 0x3002 writes, gap from STBY done to XM req = 20 cycles.
//  6 Assert I_rst during entry 100 WAIT_DONE -> outputs 0 same cycle; restart replays from index 0.

Source files
------------

// File: rtl/imx415_cfg_pkg.sv
// Shared definitions for the IMX415 configuration sequencer.
// Holds the FSM state encoding and the fixed sensor register
// addresses/values used outside the LUT walk.
package imx415_cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE           = 4'd0,
    ST_PWR_WAIT       = 4'd1,
    ST_FETCH          = 4'd2,
    ST_ISSUE          = 4'd3,
    ST_WAIT_DONE      = 4'd4,
    ST_STBY_ISSUE     = 4'd5,
    ST_STBY_WAIT_DONE = 4'd6,
    ST_STBY_DLY       = 4'd7,
    ST_XM_ISSUE       = 4'd8,
    ST_XM_WAIT_DONE   = 4'd9,
    ST_DONE           = 4'd10,
    ST_ERROR          = 4'd11
  } state_t;

  localparam logic [15:0] REG_STANDBY     = 16'h3000;
  localparam logic [15:0] REG_XMSTA       = 16'h3002;
  localparam logic [7:0]  REG_VAL_RELEASE = 8'h00;
  localparam logic [6:0]  SENSOR_I2C_ADDR = 7'h1A;
  localparam logic [8:0]  ERR_IDX_POST    = 9'h1FF;

endpackage

// File: rtl/cfg_delay_timer.sv
// 24-bit delay timer for the configuration sequencer.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - load a new delay (asserted in the cycle that triggers the wait)
//   value     - delay length N in cycles, counted from the triggering cycle
//   expired   - high in the last cycle of the wait; the FSM leaves on it
module cfg_delay_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] value,
  output logic        expired
);

  logic [23:0] count_reg;

  // The triggering cycle is the first of the N cycles, so N-1 is stored;
  // the wait state then sees expired in the cycle the count steps to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 24'd0;
    end else if (load) begin
      count_reg <= (value == 24'd0) ? 24'd0 : value - 24'd1;
    end else if (count_reg != 24'd0) begin
      count_reg <= count_reg - 24'd1;
    end
  end

  assign expired = (count_reg <= 24'd1);

endmodule

// File: rtl/imx415_cfg_seq.sv
// IMX415 configuration sequencer: waits out sensor power-up, writes every
// LUT entry through the I2C byte-write master (with NACK retries), then
// releases STANDBY, waits, and starts the sensor master mode.
// Ports:
//   I_clk, I_rst               - clock, asynchronous active-high reset
//   I_start                    - rising edge starts a run from IDLE/DONE/ERROR
//   O_reg_index / I_reg_data   - LUT lookup ({addr16,data8} in [23:0])
//   I_reg_size                 - number of LUT entries
//   O_wr_* / I_wr_rdy          - write request handshake to the I2C master
//   I_wr_done / I_wr_nack      - write completion pulse and NACK flag
//   O_busy, O_cfg_done, O_cfg_err, O_err_index - status
module imx415_cfg_seq
  import imx415_cfg_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR  = SENSOR_I2C_ADDR,
  parameter logic [23:0] PWRUP_CYC = 24'd2_500_000,
  parameter logic [23:0] STBY_CYC  = 24'd3_125_000,
  parameter int          RETRY_MAX = 2
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_start,
  output logic [8:0]  O_reg_index,
  input  logic [31:0] I_reg_data,
  input  logic [7:0]  I_reg_size,
  output logic        O_wr_req,
  input  logic        I_wr_rdy,
  output logic [6:0]  O_wr_dev,
  output logic [15:0] O_wr_addr,
  output logic [7:0]  O_wr_data,
  input  logic        I_wr_done,
  input  logic        I_wr_nack,
  output logic        O_busy,
  output logic        O_cfg_done,
  output logic        O_cfg_err,
  output logic [8:0]  O_err_index
);

  localparam logic [3:0] RETRY_LIM = 4'(RETRY_MAX);

  state_t      state_reg, state_next;
  logic        start_prev_reg;
  logic [8:0]  index_reg, index_next;
  logic [3:0]  retry_reg, retry_next;
  logic [15:0] addr_reg, addr_next;
  logic [7:0]  data_reg, data_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic [8:0]  err_index_reg, err_index_next;
  logic        tmr_load, tmr_expired;
  logic [23:0] tmr_value;
  logic        start_edge;
  logic [8:0]  last_index;
  logic        unused_data_hi;

  assign unused_data_hi = ^I_reg_data[31:24];
  assign start_edge = I_start & ~start_prev_reg;
  assign last_index = {1'b0, I_reg_size} - 9'd1;

  cfg_delay_timer u_timer (
    .clk     (I_clk),
    .rst     (I_rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      start_prev_reg <= 1'b0;
      index_reg      <= 9'd0;
      retry_reg      <= 4'd0;
      addr_reg       <= 16'd0;
      data_reg       <= 8'd0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      err_index_reg  <= 9'd0;
    end else begin
      start_prev_reg <= I_start;
      index_reg      <= index_next;
      retry_reg      <= retry_next;
      addr_reg       <= addr_next;
      data_reg       <= data_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      err_index_reg  <= err_index_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    index_next     = index_reg;
    retry_next     = retry_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    done_next      = done_reg;
    err_next       = err_reg;
    err_index_next = err_index_reg;
    tmr_load       = 1'b0;
    tmr_value      = PWRUP_CYC;

    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_edge) begin
          state_next = ST_PWR_WAIT;
          done_next  = 1'b0;
          err_next   = 1'b0;
          index_next = 9'd0;
          retry_next = 4'd0;
          tmr_load   = 1'b1;
        end
      end
      ST_PWR_WAIT: begin
        if (tmr_expired) begin
          if (I_reg_size != 8'd0) begin
            state_next = ST_FETCH;
          end else begin
            state_next = ST_STBY_ISSUE;
            addr_next  = REG_STANDBY;
            data_next  = REG_VAL_RELEASE;
          end
        end
      end
      ST_FETCH: begin
        // LUT output has had a full cycle to settle on the current index.
        addr_next  = I_reg_data[23:8];
        data_next  = I_reg_data[7:0];
        state_next = ST_ISSUE;
      end
      ST_ISSUE: if (I_wr_rdy) state_next = ST_WAIT_DONE;
      ST_STBY_ISSUE: if (I_wr_rdy) state_next = ST_STBY_WAIT_DONE;
      ST_XM_ISSUE: if (I_wr_rdy) state_next = ST_XM_WAIT_DONE;
      ST_WAIT_DONE, ST_STBY_WAIT_DONE, ST_XM_WAIT_DONE: begin
        if (I_wr_done) begin
          if (I_wr_nack) begin
            if (retry_reg < RETRY_LIM) begin
              // Re-issue the same write; address/data registers still hold it.
              retry_next = retry_reg + 4'd1;
              state_next = (state_reg == ST_WAIT_DONE)      ? ST_ISSUE :
                           (state_reg == ST_STBY_WAIT_DONE) ? ST_STBY_ISSUE : ST_XM_ISSUE;
            end else begin
              state_next     = ST_ERROR;
              err_next       = 1'b1;
              err_index_next = (state_reg == ST_WAIT_DONE) ? index_reg : ERR_IDX_POST;
            end
          end else begin
            retry_next = 4'd0;
            if (state_reg == ST_WAIT_DONE) begin
              if (index_reg == last_index) begin
                state_next = ST_STBY_ISSUE;
                addr_next  = REG_STANDBY;
                data_next  = REG_VAL_RELEASE;
              end else begin
                index_next = index_reg + 9'd1;
                state_next = ST_FETCH;
              end
            end else if (state_reg == ST_STBY_WAIT_DONE) begin
              state_next = ST_STBY_DLY;
              tmr_load   = 1'b1;
              tmr_value  = STBY_CYC;
            end else begin
              state_next = ST_DONE;
              done_next  = 1'b1;
            end
          end
        end
      end
      ST_STBY_DLY: begin
        if (tmr_expired) begin
          state_next = ST_XM_ISSUE;
          addr_next  = REG_XMSTA;
          data_next  = REG_VAL_RELEASE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign O_wr_req    = (state_reg == ST_ISSUE) || (state_reg == ST_STBY_ISSUE) ||
                       (state_reg == ST_XM_ISSUE);
  assign O_wr_dev    = O_wr_req ? DEV_ADDR : 7'd0;
  assign O_wr_addr   = addr_reg;
  assign O_wr_data   = data_reg;
  assign O_reg_index = index_reg;
  assign O_busy      = (state_reg != ST_IDLE) && (state_reg != ST_DONE) &&
                       (state_reg != ST_ERROR);
  assign O_cfg_done  = done_reg;
  assign O_cfg_err   = err_reg;
  assign O_err_index = err_index_reg;

endmodule

// File: tb/tb_imx415_cfg_seq.sv
// Directed bench for imx415_cfg_seq with a 201-entry LUT model and an
// I2C master model with programmable ready and per-address NACK count.
module tb_imx415_cfg_seq;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        I_start = 1'b0;
  logic [8:0]  O_reg_index;
  logic [31:0] I_reg_data;
  logic [7:0]  I_reg_size = 8'd201;
  logic        O_wr_req;
  logic        I_wr_rdy = 1'b1;
  logic [6:0]  O_wr_dev;
  logic [15:0] O_wr_addr;
  logic [7:0]  O_wr_data;
  logic        I_wr_done = 1'b0;
  logic        I_wr_nack = 1'b0;
  logic        O_busy, O_cfg_done, O_cfg_err;
  logic [8:0]  O_err_index;

  int checks = 0;
  int errors = 0;

  imx415_cfg_seq #(
    .PWRUP_CYC (24'd10),
    .STBY_CYC  (24'd20)
  ) dut (
    .I_clk       (I_clk),
    .I_rst       (I_rst),
    .I_start     (I_start),
    .O_reg_index (O_reg_index),
    .I_reg_data  (I_reg_data),
    .I_reg_size  (I_reg_size),
    .O_wr_req    (O_wr_req),
    .I_wr_rdy    (I_wr_rdy),
    .O_wr_dev    (O_wr_dev),
    .O_wr_addr   (O_wr_addr),
    .O_wr_data   (O_wr_data),
    .I_wr_done   (I_wr_done),
    .I_wr_nack   (I_wr_nack),
    .O_busy      (O_busy),
    .O_cfg_done  (O_cfg_done),
    .O_cfg_err   (O_cfg_err),
    .O_err_index (O_err_index)
  );

  always #5 I_clk = ~I_clk;

  // LUT model: a few fixed entries, the rest {0x3100+i, i}.
  function automatic logic [23:0] lut_entry(input int i);
    logic [15:0] a;
    logic [7:0]  d;
    a = 16'h3100 + 16'(i);
    d = 8'(i);
    if (i == 0)   return {16'h3000, 8'h01};
    if (i == 5)   return {16'h3008, 8'h5D};
    if (i == 200) return {16'h4074, 8'h01};
    return {a, d};
  endfunction

  always_comb I_reg_data = {8'h00, lut_entry(int'(O_reg_index))};

  // I2C master model, evaluated mid-cycle.
  int          neg_cnt = 0, wr_cnt = 0, dev_bad = 0;
  int          busy_first = -1, req_first = -1, stby_done_neg = -1, xm_req_neg = -1;
  logic [15:0] log_addr [0:511];
  logic [7:0]  log_data [0:511];
  int          pend = 0;
  logic        pend_nack = 1'b0;
  logic [15:0] pend_addr = 16'h0;
  logic [7:0]  pend_data = 8'h0;
  logic [15:0] nack_addr = 16'hFFFF;
  int          nack_left = 0;

  always @(negedge I_clk) begin
    neg_cnt++;
    I_wr_done = 1'b0;
    I_wr_nack = 1'b0;
    if (I_rst) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          I_wr_done = 1'b1;
          I_wr_nack = pend_nack;
          if (pend_addr == 16'h3000 && pend_data == 8'h00 && !pend_nack) stby_done_neg = neg_cnt;
        end
      end
      if (O_busy && busy_first < 0) busy_first = neg_cnt;
      if (O_wr_req && req_first < 0) req_first = neg_cnt;
      if (O_wr_req && O_wr_addr == 16'h3002 && xm_req_neg < 0) xm_req_neg = neg_cnt;
      if (O_wr_req && I_wr_rdy) begin
        if (wr_cnt < 512) begin
          log_addr[wr_cnt] = O_wr_addr;
          log_data[wr_cnt] = O_wr_data;
        end
        wr_cnt++;
        if (O_wr_dev != 7'h1A) dev_bad++;
        pend      = 3;
        pend_addr = O_wr_addr;
        pend_data = O_wr_data;
        pend_nack = (O_wr_addr == nack_addr) && (nack_left > 0);
        if (pend_nack) nack_left--;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_cnt = 0; dev_bad = 0;
    busy_first = -1; req_first = -1; stby_done_neg = -1; xm_req_neg = -1;
  endtask

  task automatic start_pulse();
    @(posedge I_clk); #1 I_start = 1'b1;
    @(posedge I_clk); #1 I_start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n;
    n = 0;
    while (!(O_cfg_done || O_cfg_err) && n < budget) begin
      @(posedge I_clk); #1;
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int bad, n3008, n5d, n;

    // Reset state
    repeat (3) @(posedge I_clk);
    #1;
    chk("rst_busy", 32'(O_busy), 32'd0);
    chk("rst_req", 32'(O_wr_req), 32'd0);
    chk("rst_done", 32'(O_cfg_done), 32'd0);
    chk("rst_err", 32'(O_cfg_err), 32'd0);
    chk("rst_err_index", 32'(O_err_index), 32'd0);
    chk("rst_reg_index", 32'(O_reg_index), 32'd0);
    I_rst = 1'b0;

    // 1: full run, always ack
    clear_log();
    start_pulse();
    wait_end("t1_timeout", 5000);
    $display("run1: writes=%0d done=%0d err=%0d", wr_cnt, O_cfg_done, O_cfg_err);
    chk("t1_wr_cnt", 32'(wr_cnt), 32'd203);
    bad = 0;
    for (int i = 0; i < 201; i++)
      if ({log_addr[i], log_data[i]} !== lut_entry(i)) bad++;
    chk("t1_lut_walk", 32'(bad), 32'd0);
    chk("t1_first", {8'h0, log_addr[0], log_data[0]}, 32'h300001);
    chk("t1_entry200", {8'h0, log_addr[200], log_data[200]}, 32'h407401);
    chk("t1_stby", {8'h0, log_addr[201], log_data[201]}, 32'h300000);
    chk("t1_xmsta", {8'h0, log_addr[202], log_data[202]}, 32'h300200);
    chk("t1_pwr_delay", 32'(req_first - busy_first), 32'd10);
    chk("t1_done", 32'(O_cfg_done), 32'd1);
    chk("t1_err", 32'(O_cfg_err), 32'd0);
    chk("t1_busy", 32'(O_busy), 32'd0);
    chk("t1_dev", 32'(dev_bad), 32'd0);

    // 2: entry 5 NACKed twice then acked
    clear_log();
    nack_addr = 16'h3008; nack_left = 2;
    start_pulse();
    wait_end("t2_timeout", 5000);
    $display("run2: writes=%0d done=%0d err=%0d", wr_cnt, O_cfg_done, O_cfg_err);
    n3008 = 0; n5d = 0;
    for (int i = 0; i < wr_cnt && i < 512; i++)
      if (log_addr[i] == 16'h3008) begin
        n3008++;
        if (log_data[i] == 8'h5D) n5d++;
      end
    chk("t2_req_3008", 32'(n3008), 32'd3);
    chk("t2_data_5d", 32'(n5d), 32'd3);
    chk("t2_wr_cnt", 32'(wr_cnt), 32'd205);
    chk("t2_done", 32'(O_cfg_done), 32'd1);

    // 3: entry 7 NACKed three times -> ERROR
    clear_log();
    nack_addr = 16'h3107; nack_left = 3;
    start_pulse();
    wait_end("t3_timeout", 5000);
    $display("run3: writes=%0d done=%0d err=%0d err_index=%0d", wr_cnt, O_cfg_done, O_cfg_err, O_err_index);
    chk("t3_err", 32'(O_cfg_err), 32'd1);
    chk("t3_done", 32'(O_cfg_done), 32'd0);
    chk("t3_err_index", 32'(O_err_index), 32'd7);
    chk("t3_wr_cnt", 32'(wr_cnt), 32'd10);
    repeat (100) @(posedge I_clk);
    #1;
    chk("t3_no_more", 32'(wr_cnt), 32'd10);
    chk("t3_idle", 32'(O_busy), 32'd0);
    nack_addr = 16'hFFFF; nack_left = 0;

    // 4: ready held low 50 cycles on the first request
    clear_log();
    I_wr_rdy = 1'b0;
    start_pulse();
    n = 0;
    while (!O_wr_req && n < 100) begin @(posedge I_clk); #1; n++; end
    chk("t4_req_seen", 32'(O_wr_req), 32'd1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!(O_wr_req === 1'b1 && O_wr_addr === 16'h3000 && O_wr_data === 8'h01)) bad++;
      @(posedge I_clk); #1;
    end
    chk("t4_stable", 32'(bad), 32'd0);
    I_wr_rdy = 1'b1;
    wait_end("t4_timeout", 5000);
    $display("run4: writes=%0d done=%0d", wr_cnt, O_cfg_done);
    chk("t4_wr_cnt", 32'(wr_cnt), 32'd203);
    chk("t4_first", {8'h0, log_addr[0], log_data[0]}, 32'h300001);

    // 5: empty LUT
    clear_log();
    I_reg_size = 8'd0;
    start_pulse();
    wait_end("t5_timeout", 2000);
    $display("run5: writes=%0d done=%0d", wr_cnt, O_cfg_done);
    chk("t5_wr_cnt", 32'(wr_cnt), 32'd2);
    chk("t5_w0", {8'h0, log_addr[0], log_data[0]}, 32'h300000);
    chk("t5_w1", {8'h0, log_addr[1], log_data[1]}, 32'h300200);
    chk("t5_stby_gap", 32'(xm_req_neg - stby_done_neg), 32'd20);
    chk("t5_done", 32'(O_cfg_done), 32'd1);

    // 6: reset while entry 100 waits for completion
    clear_log();
    I_reg_size = 8'd201;
    start_pulse();
    n = 0;
    while (wr_cnt < 101 && n < 3000) begin @(posedge I_clk); n++; end
    #1;
    chk("t6_at_100", 32'(O_reg_index), 32'd100);
    I_rst = 1'b1;
    #1;
    chk("t6_rst_req", 32'(O_wr_req), 32'd0);
    chk("t6_rst_busy", 32'(O_busy), 32'd0);
    chk("t6_rst_index", 32'(O_reg_index), 32'd0);
    chk("t6_rst_addr", 32'(O_wr_addr), 32'd0);
    repeat (3) @(posedge I_clk);
    #1 I_rst = 1'b0;
    clear_log();
    start_pulse();
    wait_end("t6_timeout", 5000);
    $display("run6: writes=%0d done=%0d", wr_cnt, O_cfg_done);
    chk("t6_wr_cnt", 32'(wr_cnt), 32'd203);
    chk("t6_replay_first", {8'h0, log_addr[0], log_data[0]}, 32'h300001);
    chk("t6_done", 32'(O_cfg_done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
